operand_entry: RTL and testbench

- Front-end controller for the multiply/display datapath.
- Collects four WIDTH-bit operands A, B, C, D from slide switches, one per debounced key press.
- Issues a start pulse to the arithmetic unit, waits for its done flag, and captures the 2*WIDTH-bit product.
- Generates the SEL_PROD/SEL_AB display selects consumed by the hex view logic.

---
 rtl/operand_entry.sv | 154 +++++++++++++++
 tb/tb_operand_entry.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// Operand entry front end: debounces the entry/restart buttons, loads A..D from the
// switches, hands off to the arithmetic unit and holds its product for display.
module operand_entry #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 250000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   SW,
  input  logic               KEY_N,
  input  logic               CLR_N,
  input  logic               DONE,
  input  logic [2*WIDTH-1:0] RESULT,
  output logic               START,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   C,
  output logic [WIDTH-1:0]   D,
  output logic [2*WIDTH-1:0] PROD,
  output logic               SEL_PROD,
  output logic               SEL_AB,
  output logic               BUSY
);

  localparam int CW = $clog2(DEBOUNCE);

  typedef enum logic [2:0] {
    ST_LOAD_A, ST_LOAD_B, ST_LOAD_C, ST_LOAD_D, ST_CALC, ST_WAIT, ST_SHOW
  } state_t;

  // Index 0 is the entry key, index 1 the restart key; both idle high.
  logic [1:0] btn_n;
  logic [1:0] strobe;

  assign btn_n = {CLR_N, KEY_N};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          meta_q, sync_q, level_q, level_d;
      logic [CW-1:0] cnt_q, cnt_d;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          meta_q  <= 1'b1;
          sync_q  <= 1'b1;
          level_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          meta_q  <= btn_n[gi];
          sync_q  <= meta_q;
          level_q <= level_d;
          cnt_q   <= cnt_d;
        end
      end

      // The count only survives while the synchronized input disagrees with the accepted level.
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
          if (cnt_q == CW'(DEBOUNCE - 1)) begin
            level_d = sync_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      assign strobe[gi] = level_q & ~level_d;
    end
  endgenerate

  logic key_stb, clr_stb;
  assign key_stb = strobe[0];
  assign clr_stb = strobe[1];

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 sel_prod_q, sel_prod_d, sel_ab_q, sel_ab_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      prod_q     <= '0;
      sel_prod_q <= 1'b0;
      sel_ab_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      prod_q     <= prod_d;
      sel_prod_q <= sel_prod_d;
      sel_ab_q   <= sel_ab_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    d_d        = d_q;
    prod_d     = prod_q;
    sel_prod_d = sel_prod_q;
    sel_ab_d   = sel_ab_q;
    if (clr_stb) begin
      state_d    = ST_LOAD_A;
      sel_prod_d = 1'b0;
      sel_ab_d   = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD_A: if (key_stb) begin a_d = SW; state_d = ST_LOAD_B; end
        ST_LOAD_B: if (key_stb) begin b_d = SW; state_d = ST_LOAD_C; sel_ab_d = 1'b0; end
        ST_LOAD_C: if (key_stb) begin c_d = SW; state_d = ST_LOAD_D; end
        ST_LOAD_D: if (key_stb) begin d_d = SW; state_d = ST_CALC; end
        ST_CALC:   state_d = ST_WAIT;
        ST_WAIT: begin
          if (DONE) begin
            prod_d     = RESULT;
            state_d    = ST_SHOW;
            sel_prod_d = 1'b1;
            sel_ab_d   = 1'b0;
          end
        end
        ST_SHOW: begin
          // Each return to the operand view alternates between the A/B and C/D pages.
          if (key_stb) begin
            sel_prod_d = ~sel_prod_q;
            if (sel_prod_q) sel_ab_d = ~sel_ab_q;
          end
        end
        default:   state_d = ST_LOAD_A;
      endcase
    end
  end

  assign START    = (state_q == ST_CALC);
  assign BUSY     = (state_q == ST_CALC) || (state_q == ST_WAIT);
  assign A        = a_q;
  assign B        = b_q;
  assign C        = c_q;
  assign D        = d_q;
  assign PROD     = prod_q;
  assign SEL_PROD = sel_prod_q;
  assign SEL_AB   = sel_ab_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: a window-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_operand_entry;
  localparam int W   = 8;
  localparam int DEB = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic [W-1:0]  sw = '0;
  logic          key_n = 1'b1, clr_n = 1'b1, done = 1'b0;
  logic [2*W-1:0] result = '0;
  logic          start, sel_prod, sel_ab, busy;
  logic [W-1:0]  a, b, c, d;
  logic [2*W-1:0] prod;

  operand_entry #(.WIDTH(W), .DEBOUNCE(DEB)) dut (
    .CLK(clk), .RST(rst), .SW(sw), .KEY_N(key_n), .CLR_N(clr_n),
    .DONE(done), .RESULT(result), .START(start),
    .A(a), .B(b), .C(c), .D(d), .PROD(prod),
    .SEL_PROD(sel_prod), .SEL_AB(sel_ab), .BUSY(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, start_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_LA, M_LB, M_LC, M_LD, M_CALC, M_WAIT, M_SHOW} mstate_t;
  mstate_t       m_state;
  logic [W-1:0]  m_a, m_b, m_c, m_d;
  logic [2*W-1:0] m_prod;
  int            m_show_presses;
  logic          m_key_lvl, m_clr_lvl;
  logic [7:0]    m_key_hist, m_clr_hist;   // bit0 = sample at the previous edge
  logic          m_p, m_cl, m_sel_prod, m_sel_ab, m_start, m_busy;

  // A level is accepted once the input, seen through two sync stages, has differed from it
  // for DEB consecutive cycles.
  function automatic bit settled(input logic lvl, input logic [7:0] hist);
    for (int i = 1; i <= DEB; i++) if (hist[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  assign m_p  = m_key_lvl && settled(m_key_lvl, m_key_hist);
  assign m_cl = m_clr_lvl && settled(m_clr_lvl, m_clr_hist);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= M_LA; m_a <= '0; m_b <= '0; m_c <= '0; m_d <= '0; m_prod <= '0;
      m_show_presses <= 0; m_key_lvl <= 1'b1; m_clr_lvl <= 1'b1;
      m_key_hist <= '1; m_clr_hist <= '1;
    end else begin
      m_key_hist <= {m_key_hist[6:0], key_n};
      m_clr_hist <= {m_clr_hist[6:0], clr_n};
      if (settled(m_key_lvl, m_key_hist)) m_key_lvl <= ~m_key_lvl;
      if (settled(m_clr_lvl, m_clr_hist)) m_clr_lvl <= ~m_clr_lvl;
      if (m_cl) m_state <= M_LA;
      else begin
        case (m_state)
          M_LA:   if (m_p) begin m_a <= sw; m_state <= M_LB; end
          M_LB:   if (m_p) begin m_b <= sw; m_state <= M_LC; end
          M_LC:   if (m_p) begin m_c <= sw; m_state <= M_LD; end
          M_LD:   if (m_p) begin m_d <= sw; m_state <= M_CALC; end
          M_CALC: m_state <= M_WAIT;
          M_WAIT: if (done) begin m_prod <= result; m_state <= M_SHOW; m_show_presses <= 0; end
          M_SHOW: if (m_p) m_show_presses <= m_show_presses + 1;
          default: m_state <= M_LA;
        endcase
      end
    end
  end

  always_comb begin
    m_sel_prod = 1'b0;
    m_sel_ab   = 1'b0;
    m_start    = (m_state == M_CALC);
    m_busy     = (m_state == M_CALC) || (m_state == M_WAIT);
    case (m_state)
      M_LA, M_LB: m_sel_ab = 1'b1;
      M_SHOW: begin
        m_sel_prod = (m_show_presses % 2) == 0;
        m_sel_ab   = (((m_show_presses + 1) / 2) % 2) == 1;
      end
      default: m_sel_ab = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle", {a, b, c, d, prod, start, sel_prod, sel_ab, busy},
            {m_a, m_b, m_c, m_d, m_prod, m_start, m_sel_prod, m_sel_ab, m_busy});
      if (start) start_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [W-1:0] v);
    sw = v;
    $display("press sw=%02h", v);
    key_n = 1'b0; tick(10);
    key_n = 1'b1; tick(10);
  endtask

  task automatic clear_press();
    $display("restart press");
    clr_n = 1'b0; tick(10);
    clr_n = 1'b1; tick(10);
  endtask

  task automatic wait_start(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = start;
    end
    check(name, {63'd0, seen}, 64'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_a", a, 0);
    check("rst_prod", prod, 0);
    check("rst_sel_ab", sel_ab, 1);
    check("rst_sel_prod", sel_prod, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);

    // four operand loads and a computation
    press(8'h12); check("load_a", a, 8'h12); check("sel_ab_lb", sel_ab, 1);
    press(8'h34); check("load_b", b, 8'h34); check("sel_ab_lc", sel_ab, 0);
    press(8'h56); check("load_c", c, 8'h56); check("sel_ab_ld", sel_ab, 0);
    sw = 8'h78;
    $display("press sw=78");
    key_n = 1'b0;
    wait_start("start_seen_1");
    repeat (5) @(posedge clk);
    #1 result = 16'h0F6C; done = 1'b1;
    tick(1);
    done = 1'b0;
    key_n = 1'b1;
    tick(10);
    check("load_d", d, 8'h78);
    check("prod_1", prod, 16'h0F6C);
    check("show_sel_prod", sel_prod, 1);
    check("show_busy", busy, 0);
    check("start_count_1", start_cnt, 1);

    // view toggling in SHOW
    press(8'h00); check("tog1_prod", sel_prod, 0); check("tog1_ab", sel_ab, 1);
    press(8'h00); check("tog2_prod", sel_prod, 1);
    press(8'h00); check("tog3_prod", sel_prod, 0); check("tog3_ab", sel_ab, 0);

    clear_press();
    check("clr_sel_prod", sel_prod, 0);
    check("clr_sel_ab", sel_ab, 1);
    check("clr_keeps_a", a, 8'h12);
    check("clr_keeps_prod", prod, 16'h0F6C);

    // bouncing key: one load only
    sw = 8'h9A;
    $display("bounce sw=9a");
    for (int i = 0; i < 3; i++) begin
      key_n = 1'b0; tick(2);
      key_n = 1'b1; tick(2);
    end
    key_n = 1'b0;
    tick(1000);
    check("bounce_a", a, 8'h9A);
    check("bounce_b", b, 8'h34);
    check("bounce_sel_ab", sel_ab, 1);
    key_n = 1'b1;
    tick(10);

    // presses ignored in WAIT, abandoned computation ignores DONE
    press(8'h11); press(8'h22); press(8'h33);
    check("wait_busy", busy, 1);
    press(8'h44);
    check("wait_ignores_d", d, 8'h33);
    check("wait_still_busy", busy, 1);
    check("start_count_2", start_cnt, 2);
    clear_press();
    check("abandon_busy", busy, 0);
    $display("late done result=beef");
    result = 16'hBEEF; done = 1'b1; tick(1); done = 1'b0; tick(2);
    check("late_done_prod", prod, 16'h0F6C);
    check("late_done_sel_prod", sel_prod, 0);

    // asynchronous reset in LOAD_C
    press(8'hAA); press(8'hBB);
    check("pre_rst_a", a, 8'hAA);
    check("pre_rst_sel_ab", sel_ab, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    $display("async reset");
    #1;
    check("arst_a", a, 0);
    check("arst_b", b, 0);
    check("arst_sel_ab", sel_ab, 1);
    check("arst_busy", busy, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick(2);

    // restart and DONE in the same cycle
    press(8'h01); press(8'h02); press(8'h03); press(8'h04);
    check("wait2_busy", busy, 1);
    $display("restart with done");
    clr_n = 1'b0;
    tick(5);
    result = 16'hBEEF; done = 1'b1;
    tick(1);
    done = 1'b0;
    check("cl_done_prod", prod, 0);
    check("cl_done_sel_prod", sel_prod, 0);
    check("cl_done_sel_ab", sel_ab, 1);
    check("cl_done_busy", busy, 0);
    clr_n = 1'b1;
    tick(10);
    check("cl_done_start_count", start_cnt, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
